// File: rtl/tmds_decoder.sv
// TMDS receiver: per-channel bit-slip word alignment on control tokens, then 8b/10b data decode
// into r/g/b/de/hsync/vsync with a two-register pipeline.
module tmds_decoder #(
  parameter int unsigned LOCK_RUN     = 16,
  parameter int unsigned SLIP_TIMEOUT = 2048,
  parameter int unsigned LOSS_TIMEOUT = 4096
) (
  input  logic        clk_pix,
  input  logic        rst_pix,
  input  logic [29:0] tmds_in,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        locked,
  output logic [2:0]  ch_locked,
  output logic [11:0] slip_offset
);

  localparam int unsigned RunW   = $clog2(LOCK_RUN + 1);
  localparam int unsigned TimeMx = (SLIP_TIMEOUT > LOSS_TIMEOUT) ? SLIP_TIMEOUT : LOSS_TIMEOUT;
  localparam int unsigned TimerW = $clog2(TimeMx + 1);

  typedef enum logic {StSearch, StLocked} ch_state_e;

  logic [9:0]        prev_q  [3];
  logic [3:0]        offset_q[3];
  ch_state_e         state_q [3];
  logic [RunW-1:0]   run_q   [3];
  logic [TimerW-1:0] timer_q [3];

  logic [9:0]        win      [3];
  logic              is_ctrl  [3];
  logic [1:0]        ctrl_val [3];
  logic [RunW-1:0]   run_nxt  [3];
  logic [TimerW-1:0] timer_inc[3];
  logic              run_hit  [3];

  logic [7:0] r_q, g_q, b_q;
  logic       de_q, hsync_q, vsync_q;
  logic       all_data;

  function automatic logic [7:0] tmds_data(input logic [9:0] q);
    logic [7:0] d;
    logic [7:0] o;
    d    = q[9] ? ~q[7:0] : q[7:0];
    o    = '0;
    o[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      o[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return o;
  endfunction

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      // Previous word sits in the low half, so offset 0 selects the previous word.
      win[c] = 10'({tmds_in[10*c +: 10], prev_q[c]} >> offset_q[c]);
      is_ctrl[c]  = 1'b1;
      ctrl_val[c] = 2'b00;
      case (win[c])
        10'b1101010100: ctrl_val[c] = 2'b00;
        10'b0010101011: ctrl_val[c] = 2'b01;
        10'b0101010100: ctrl_val[c] = 2'b10;
        10'b1010101011: ctrl_val[c] = 2'b11;
        default:        is_ctrl[c]  = 1'b0;
      endcase
      run_nxt[c]   = !is_ctrl[c] ? '0 :
                     (run_q[c] == RunW'(LOCK_RUN)) ? run_q[c] : run_q[c] + 1'b1;
      timer_inc[c] = (&timer_q[c]) ? timer_q[c] : timer_q[c] + 1'b1;
      run_hit[c]   = (run_nxt[c] == RunW'(LOCK_RUN));
    end
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      for (int c = 0; c < 3; c++) begin
        prev_q[c]   <= '0;
        offset_q[c] <= '0;
        state_q[c]  <= StSearch;
        run_q[c]    <= '0;
        timer_q[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        prev_q[c] <= tmds_in[10*c +: 10];
        case (state_q[c])
          StSearch: begin
            if (run_hit[c]) begin
              state_q[c] <= StLocked;
              run_q[c]   <= '0;
              timer_q[c] <= '0;
            end else if (timer_inc[c] == TimerW'(SLIP_TIMEOUT)) begin
              offset_q[c] <= (offset_q[c] == 4'd9) ? 4'd0 : offset_q[c] + 4'd1;
              run_q[c]    <= '0;
              timer_q[c]  <= '0;
            end else begin
              run_q[c]   <= run_nxt[c];
              timer_q[c] <= timer_inc[c];
            end
          end
          StLocked: begin
            if (!run_hit[c] && timer_inc[c] == TimerW'(LOSS_TIMEOUT)) begin
              state_q[c] <= StSearch;
              run_q[c]   <= '0;
              timer_q[c] <= '0;
            end else begin
              run_q[c]   <= run_nxt[c];
              timer_q[c] <= run_hit[c] ? '0 : timer_inc[c];
            end
          end
          default: state_q[c] <= StSearch;
        endcase
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      ch_locked[c] = (state_q[c] == StLocked);
    end
  end

  assign locked      = &ch_locked;
  assign slip_offset = {offset_q[2], offset_q[1], offset_q[0]};
  assign all_data    = !is_ctrl[0] && !is_ctrl[1] && !is_ctrl[2];

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      de_q    <= 1'b0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
    end else if (!locked) begin
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      de_q    <= 1'b0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      de_q <= all_data;
      r_q  <= all_data ? tmds_data(win[2]) : 8'h00;
      g_q  <= all_data ? tmds_data(win[1]) : 8'h00;
      b_q  <= all_data ? tmds_data(win[0]) : 8'h00;
      if (is_ctrl[0]) begin
        hsync_q <= ctrl_val[0][0];
        vsync_q <= ctrl_val[0][1];
      end
    end
  end

  // Gate with the live lock state so a loss of lock blanks outputs in the same cycle.
  assign r     = r_q & {8{locked}};
  assign g     = g_q & {8{locked}};
  assign b     = b_q & {8{locked}};
  assign de    = de_q & locked;
  assign hsync = hsync_q & locked;
  assign vsync = vsync_q & locked;

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: reset, lock, decode, loss of lock, bit-slip and async reset.
module tb_tmds_decoder;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T11 = 10'b1010101011;

  logic        clk_pix = 1'b0;
  logic        rst_pix;
  logic [29:0] tmds_in;
  logic [7:0]  r, g, b;
  logic        de, hsync, vsync, locked;
  logic [2:0]  ch_locked;
  logic [11:0] slip_offset;
  logic [29:0] orig_prev;

  int checks = 0;
  int errors = 0;

  tmds_decoder dut (
    .clk_pix     (clk_pix),
    .rst_pix     (rst_pix),
    .tmds_in     (tmds_in),
    .r           (r),
    .g           (g),
    .b           (b),
    .de          (de),
    .hsync       (hsync),
    .vsync       (vsync),
    .locked      (locked),
    .ch_locked   (ch_locked),
    .slip_offset (slip_offset)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] all3(input logic [9:0] w);
    return {w, w, w};
  endfunction

  // Hold a word across one rising edge; returns at the following falling edge.
  task automatic send(input logic [29:0] w);
    tmds_in = w;
    @(negedge clk_pix);
  endtask

  // Serial stream delayed by 3 bits before word splitting.
  task automatic send_shift(input logic [29:0] w);
    logic [29:0] s;
    for (int c = 0; c < 3; c++) begin
      s[10*c +: 10] = {w[10*c +: 7], orig_prev[10*c+7 +: 3]};
    end
    orig_prev = w;
    send(s);
  endtask

  initial begin
    int n;
    rst_pix   = 1'b1;
    tmds_in   = '0;
    orig_prev = all3(T00);

    // Reset with random input
    for (int i = 0; i < 4; i++) begin
      tmds_in = 30'($urandom);
      @(negedge clk_pix);
      check("rst_out", {r, g, b, de, hsync, vsync}, 0);
      check("rst_lock", {locked, ch_locked, slip_offset}, 0);
    end
    rst_pix = 1'b0;
    for (int i = 0; i < 15; i++) begin
      send(all3(T00));
      check("rst_quiet", {locked, de, hsync, vsync, r, g, b}, 0);
    end

    // Aligned lock
    for (int i = 0; i < 5; i++) send(all3(T00));
    check("lock_ch", ch_locked, 3'b111);
    check("lock_all", locked, 1);
    check("lock_off", slip_offset, 0);
    check("lock_sync", {hsync, vsync}, 0);

    // Decode
    for (int i = 0; i < 20; i++) send(all3(T00));
    send({10'h100, 10'h200, 10'h100});
    send({10'h3F0, 10'h055, 10'h1AA});
    check("dec1_de", de, 1);
    check("dec1_rgb", {r, g, b}, 24'h00FF00);
    check("dec1_sync", {hsync, vsync}, 0);
    send({T00, T00, T11});
    check("dec2_de", de, 1);
    check("dec2_rgb", {r, g, b}, 24'h1101FE);
    send({T00, T00, T01});
    check("tok11", {de, hsync, vsync}, 3'b011);
    check("tok11_rgb", {r, g, b}, 0);
    send({10'h100, T00, 10'h100});
    check("tok01", {de, hsync, vsync}, 3'b010);
    send(all3(T00));
    check("ch1_ctrl", {de, hsync, vsync, r, g, b}, 27'h2000000);
    send(all3(T00));
    check("tok00", {de, hsync, vsync}, 0);

    // Loss of lock
    for (int i = 0; i < 20; i++) send(all3(T00));
    for (int i = 0; i < 4000; i++) send(all3(10'h100));
    check("loss_hold", locked, 1);
    check("loss_hold_de", de, 1);
    for (int i = 0; i < 100; i++) send(all3(10'h100));
    check("loss_lock", {locked, ch_locked}, 0);
    check("loss_out", {r, g, b, de, hsync, vsync}, 0);
    check("loss_off", slip_offset, 0);
    for (int i = 0; i < 20; i++) send(all3(T00));
    check("relock", locked, 1);

    // Bit-slip with a 3-bit delay
    rst_pix = 1'b1;
    @(negedge clk_pix);
    rst_pix = 1'b0;
    for (int i = 0; i < 2060; i++) send_shift(all3(T00));
    check("slip1", {locked, slip_offset}, 13'h0111);
    for (int i = 0; i < 2050; i++) send_shift(all3(T00));
    check("slip2", {locked, slip_offset}, 13'h0222);
    n = 0;
    while (!locked && n < 2500) begin
      send_shift(all3(T00));
      n++;
    end
    check("slip_lock", locked, 1);
    check("slip3", slip_offset, 12'h333);
    send_shift({10'h100, 10'h200, 10'h100});
    send_shift({T00, T00, T11});
    check("slip_dec", {de, r, g, b}, 25'h100FF00);
    send_shift(all3(T00));
    check("slip_tok", {de, hsync, vsync}, 3'b011);

    // Asynchronous reset between edges
    #2 rst_pix = 1'b1;
    #1;
    check("arst_lock", {locked, ch_locked}, 0);
    check("arst_off", slip_offset, 0);
    #1 rst_pix = 1'b0;
    @(negedge clk_pix);
    check("arst_after", {locked, de, hsync, vsync, r, g, b}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
